// File: rtl/neuron_pkg.sv
// neuron_pkg: shared constants and types for the neuron MAC front end.
//   DEF_DATA_W / DEF_FRAC_W / DEF_ACC_W : default widths (Q4.4 data, 20-bit accumulator)
//   fx_t    : signed Q4.4 sample / weight / result
//   acc_t   : signed accumulator (Q12.8 at default widths)
//   state_t : MAC sequencer states
package neuron_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_ACC_W  = 20;

  typedef logic signed [DEF_DATA_W-1:0] fx_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    ROUND,
    OUT
  } state_t;

endpackage

// File: rtl/neuron_mac_requant.sv
// neuron_mac_requant: combinational round-and-narrow of the MAC accumulator.
// The accumulator holds 2*FRAC_W fractional bits; this drops FRAC_W of them,
// rounding half toward +inf, and narrows the result to DATA_W bits.
// Optional feature macro: NEURON_MAC_SAT_EN
//   defined   -> result saturates to the most negative / most positive DATA_W value
//   undefined -> result wraps (two's-complement truncation)
// Ports:
//   acc : in  ACC_W  signed accumulator
//   z   : out DATA_W signed requantised value
module neuron_mac_requant
  import neuron_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] z
);

  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(2 ** (FRAC_W-1));

  // One extra bit so adding the rounding constant can never overflow.
  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] r;

  assign rounded = {acc[ACC_W-1], acc} + HALF;
  assign r       = rounded >>> FRAC_W;

`ifdef NEURON_MAC_SAT_EN
  localparam logic signed [ACC_W:0] Z_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] Z_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    z = r[DATA_W-1:0];
    if (r > Z_MAX) begin
      z = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (r < Z_MIN) begin
      z = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end
`else
  // Upper bits are simply discarded in the wrapping build.
  logic unused_r;
  assign unused_r = ^r[ACC_W:DATA_W];
  assign z        = r[DATA_W-1:0];
`endif

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: per-neuron multiply-accumulate front end.
// Computes z = bias + sum(w[i]*x[i]) over N_INPUTS Q4.4 samples (one per
// accepted handshake), rounds to Q4.4 and presents it on z_value with a
// valid/ready handshake. z_value[7:4] feeds the activation LUT address and
// z_value[3:0] the interpolation remainder downstream.
// Optional feature macro: NEURON_MAC_SAT_EN (saturate instead of wrap, see
// neuron_mac_requant).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   w_wr_en/addr/data     : weight (addr 0..N_INPUTS-1) or bias (addr N_INPUTS) write, IDLE only
//   x_valid/x_ready/x_data: input sample stream
//   z_valid/z_ready/z_value: result stream
//   busy                  : high whenever not in IDLE
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int ACC_W    = DEF_ACC_W,
  localparam int AW      = $clog2(N_INPUTS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_wr_en,
  input  logic [AW-1:0]     w_wr_addr,
  input  logic [DATA_W-1:0] w_wr_data,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data,
  output logic              z_valid,
  input  logic              z_ready,
  output logic [DATA_W-1:0] z_value,
  output logic              busy
);

  localparam int CW = $clog2(N_INPUTS);
  localparam int PW = 2 * DATA_W;

  state_t                   state;
  logic [CW-1:0]            count;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] weight [N_INPUTS];
  logic signed [DATA_W-1:0] bias;

  logic signed [PW-1:0]     w_ext;
  logic signed [PW-1:0]     x_ext;
  logic signed [PW-1:0]     product;
  logic signed [ACC_W-1:0]  product_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [DATA_W-1:0] z_round;
  logic                     x_fire;
  logic                     last_sample;

  // Operands are widened before multiplying so the Q8.8 product is exact.
  always_comb begin
    w_ext       = {{(PW-DATA_W){weight[count][DATA_W-1]}}, weight[count]};
    x_ext       = {{(PW-DATA_W){x_data[DATA_W-1]}}, x_data};
    product     = w_ext * x_ext;
    product_ext = {{(ACC_W-PW){product[PW-1]}}, product};
    // Bias is Q4.4; shifting by FRAC_W aligns it with the Q.8 products.
    bias_ext    = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
  end

  assign x_fire      = x_valid & x_ready;
  assign last_sample = (count == CW'(N_INPUTS - 1));

  neuron_mac_requant #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_requant (
    .acc (acc),
    .z   (z_round)
  );

  // Weight/bias store. Only written while idle, so a vector in flight always
  // sees a consistent parameter set; a same-cycle handshake reads the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        weight[i] <= '0;
      end
      bias <= '0;
    end else if (w_wr_en && (state == IDLE)) begin
      if (w_wr_addr < AW'(N_INPUTS)) begin
        weight[w_wr_addr[CW-1:0]] <= w_wr_data;
      end else if (w_wr_addr == AW'(N_INPUTS)) begin
        bias <= w_wr_data;
      end
    end
  end

  // Sequencer with registered handshake outputs. x_ready comes up on the
  // first clock after reset and drops on entry to ROUND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      x_ready <= 1'b0;
      z_valid <= 1'b0;
      z_value <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          x_ready <= 1'b1;
          if (x_fire) begin
            acc  <= bias_ext + product_ext;
            busy <= 1'b1;
            if (last_sample) begin
              count   <= '0;
              x_ready <= 1'b0;
              state   <= ROUND;
            end else begin
              count <= count + 1'b1;
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (x_fire) begin
            acc <= acc + product_ext;
            if (last_sample) begin
              count   <= '0;
              x_ready <= 1'b0;
              state   <= ROUND;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ROUND: begin
          z_value <= z_round;
          z_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (z_ready && z_valid) begin
            z_valid <= 1'b0;
            count   <= '0;
            x_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: self-checking bench for neuron_mac. Directed vectors from the
// test plan plus randomized vectors, all checked against a plain-arithmetic
// reference model. Honours NEURON_MAC_SAT_EN for the expected narrowing.
module tb_neuron_mac;
  import neuron_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       w_wr_en = 1'b0;
  logic [2:0] w_wr_addr = '0;
  logic [7:0] w_wr_data = '0;
  logic       x_valid = 1'b0;
  logic       x_ready;
  logic [7:0] x_data = '0;
  logic       z_valid;
  logic       z_ready = 1'b0;
  logic [7:0] z_value;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int wmod[N];
  int bmod;

  neuron_mac #(.N_INPUTS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_wr_en   (w_wr_en),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x_data    (x_data),
    .z_valid   (z_valid),
    .z_ready   (z_ready),
    .z_value   (z_value),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int toSigned8(input int v);
    int b;
    b = v & 255;
    return (b > 127) ? b - 256 : b;
  endfunction

  // Reference: exact real-valued sum scaled by 256, rounded half up to 1/16,
  // then saturated or wrapped to a byte.
  function automatic int modelZ(input int xs[N]);
    longint s;
    longint r;
    s = longint'(bmod) * 16;
    for (int i = 0; i < N; i++) begin
      s += longint'(wmod[i] * toSigned8(xs[i]));
    end
    s += 8;
    if (s >= 0) r = s / 16;
    else        r = -((-s + 15) / 16);
`ifdef NEURON_MAC_SAT_EN
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
`endif
    return int'(r) & 255;
  endfunction

  task automatic writeParam(input int addr, input int data);
    w_wr_en   = 1'b1;
    w_wr_addr = addr[2:0];
    w_wr_data = data[7:0];
    @(posedge clk); #1;
    w_wr_en = 1'b0;
    if (addr < N)       wmod[addr] = toSigned8(data);
    else if (addr == N) bmod = toSigned8(data);
  endtask

  task automatic writeAll(input int wv, input int bv);
    for (int i = 0; i < N; i++) writeParam(i, wv);
    writeParam(N, bv);
  endtask

  // Runs one full vector: samples (with gap idle cycles before each), the
  // ROUND/OUT latency checks, hold cycles of backpressure, then the pop.
  task automatic applyStimulus(input int xs[N], input int gap, input int hold,
                               input bit wr_mid, input bit wr_first, input int first_val,
                               input bit zr_early, output logic [7:0] zobs);
    int expz;
    int guard;
    expz = modelZ(xs);
    zobs = '0;
    z_ready = zr_early;
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        if (wr_mid && i > 0) begin
          w_wr_en   = 1'b1;
          w_wr_addr = 3'($urandom_range(0, N));
          w_wr_data = 8'($urandom);
        end
        @(posedge clk); #1;
        w_wr_en = 1'b0;
      end
      x_valid = 1'b1;
      x_data  = xs[i][7:0];
      if (wr_first && i == 0) begin
        w_wr_en   = 1'b1;
        w_wr_addr = 3'd0;
        w_wr_data = first_val[7:0];
      end
      guard = 0;
      @(negedge clk);
      while (!x_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!x_ready) begin
        checkOutput("x_ready timeout", {31'b0, x_ready}, 32'd1);
        x_valid = 1'b0;
        w_wr_en = 1'b0;
        z_ready = 1'b0;
        return;
      end
      @(posedge clk); #1;
      x_valid = 1'b0;
      w_wr_en = 1'b0;
      if (wr_first && i == 0) wmod[0] = toSigned8(first_val);
    end
    z_ready = 1'b0;
    @(negedge clk);
    checkOutput("round z_valid", {31'b0, z_valid}, 32'd0);
    checkOutput("round x_ready", {31'b0, x_ready}, 32'd0);
    checkOutput("round busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("latency z_valid", {31'b0, z_valid}, 32'd1);
    checkOutput("z_value", {24'h0, z_value}, 32'(expz));
    zobs = z_value;
    for (int h = 0; h < hold; h++) begin
      if (wr_mid) begin
        w_wr_en   = 1'b1;
        w_wr_addr = 3'($urandom_range(0, N));
        w_wr_data = 8'($urandom);
      end
      @(negedge clk);
      w_wr_en = 1'b0;
      checkOutput("hold z_valid", {31'b0, z_valid}, 32'd1);
      checkOutput("hold z_value", {24'h0, z_value}, 32'(expz));
      checkOutput("hold x_ready", {31'b0, x_ready}, 32'd0);
    end
    z_ready = 1'b1;
    @(posedge clk); #1;
    z_ready = 1'b0;
    @(negedge clk);
    checkOutput("pop z_valid", {31'b0, z_valid}, 32'd0);
    checkOutput("pop x_ready", {31'b0, x_ready}, 32'd1);
    checkOutput("pop busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int xs[N];
    logic [7:0] zo;
    int exp_sat_pos;
    int exp_sat_neg;

    for (int i = 0; i < N; i++) wmod[i] = 0;
    bmod = 0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset z_valid", {31'b0, z_valid}, 32'd0);
    checkOutput("reset x_ready", {31'b0, x_ready}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset z_value", {24'h0, z_value}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Unit weights, mixed samples -> 2.5
    writeAll(8'h10, 8'h00);
    xs = '{8'h10, 8'h20, 8'h08, 8'hF0};
    applyStimulus(xs, 0, 0, 1'b0, 1'b0, 0, 1'b0, zo);
    checkOutput("unit weights const", {24'h0, zo}, 32'h28);

    // Overflow: saturate or wrap
`ifdef NEURON_MAC_SAT_EN
    exp_sat_pos = 8'h7F;
    exp_sat_neg = 8'h80;
`else
    exp_sat_pos = 8'h40;
    exp_sat_neg = 8'h00;
`endif
    writeAll(8'h70, 8'h00);
    xs = '{8'h70, 8'h70, 8'h70, 8'h70};
    applyStimulus(xs, 0, 1, 1'b0, 1'b0, 0, 1'b0, zo);
    checkOutput("overflow pos const", {24'h0, zo}, 32'(exp_sat_pos));
    xs = '{8'h80, 8'h80, 8'h80, 8'h80};
    applyStimulus(xs, 0, 0, 1'b0, 1'b0, 0, 1'b0, zo);
    checkOutput("overflow neg const", {24'h0, zo}, 32'(exp_sat_neg));

    // Rounding half toward +inf
    writeAll(8'h00, 8'h00);
    writeParam(0, 8'h01);
    xs = '{8'h08, 8'h00, 8'h00, 8'h00};
    applyStimulus(xs, 0, 0, 1'b0, 1'b0, 0, 1'b0, zo);
    checkOutput("round up const", {24'h0, zo}, 32'h01);
    xs = '{8'hF8, 8'h00, 8'h00, 8'h00};
    applyStimulus(xs, 0, 0, 1'b0, 1'b0, 0, 1'b0, zo);
    checkOutput("round neg half const", {24'h0, zo}, 32'h00);

    // Backpressure for 5 cycles with z_ready high early (no effect before z_valid)
    writeAll(8'h10, 8'h00);
    for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(0, 255));
    applyStimulus(xs, 1, 5, 1'b0, 1'b0, 0, 1'b1, zo);

    // Gapped samples, bias 1.5, ignored writes mid-vector and during OUT
    writeAll(8'h10, 8'h18);
    xs = '{8'h10, 8'h10, 8'h10, 8'h10};
    applyStimulus(xs, 2, 2, 1'b1, 1'b0, 0, 1'b0, zo);
    checkOutput("gapped bias const", {24'h0, zo}, 32'h58);

    // Write in the same IDLE cycle as the first handshake uses the old weight
    writeAll(8'h10, 8'h00);
    applyStimulus(xs, 0, 0, 1'b0, 1'b1, 8'h20, 1'b0, zo);
    checkOutput("same-cycle write old const", {24'h0, zo}, 32'h40);
    applyStimulus(xs, 0, 0, 1'b0, 1'b0, 0, 1'b0, zo);
    checkOutput("same-cycle write new const", {24'h0, zo}, 32'h50);

    // Out-of-range addresses are ignored
    writeParam(5, 8'h7F);
    writeParam(7, 8'h55);
    applyStimulus(xs, 0, 0, 1'b0, 1'b0, 0, 1'b0, zo);
    checkOutput("bad addr const", {24'h0, zo}, 32'h50);

    // Reset mid-vector aborts and clears parameters
    writeAll(8'h10, 8'h18);
    for (int i = 0; i < 2; i++) begin
      x_valid = 1'b1;
      x_data  = 8'h10;
      @(negedge clk);
      checkOutput("pre-reset x_ready", {31'b0, x_ready}, 32'd1);
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort z_valid", {31'b0, z_valid}, 32'd0);
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort x_ready", {31'b0, x_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) wmod[i] = 0;
    bmod = 0;
    for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(0, 255));
    applyStimulus(xs, 0, 0, 1'b0, 1'b0, 0, 1'b0, zo);
    checkOutput("post-reset zero const", {24'h0, zo}, 32'h00);

    // Randomized vectors
    for (int t = 0; t < 16; t++) begin
      int nw;
      nw = int'($urandom_range(0, 4));
      for (int k = 0; k < nw; k++) begin
        writeParam(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      end
      for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(0, 255));
      applyStimulus(xs, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), zo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Upstream stage of the per-neuron activation unit (LUT + linear interpolator).
- Computes z = bias + Σ wᵢ·xᵢ over N_INPUTS signed Q4.4 samples, one sample per cycle.
- Rounds and requantises the sum to 8-bit signed Q4.4, then presents it as z_value to the activation stage.
- z_value[7:4] is the activation LUT address and z_value[3:0] the interpolation remainder, so the Q4.4 format is mandatory.

Parameters:
- N_INPUTS, 4, inputs (and weights) per neuron; ≥2.
- DATA_W, 8, width of x, weight, bias and z.
- FRAC_W, 4, fractional bits of every DATA_W quantity.
- ACC_W, 20, accumulator width; must be ≥ 2·DATA_W + clog2(N_INPUTS+1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- w_wr_en  in  1  parameter write strobe
- w_wr_addr  in  clog2(N_INPUTS+1)  0..N_INPUTS-1 selects a weight; N_INPUTS selects the bias
- w_wr_data  in  DATA_W  signed Q4.4 weight or bias
- x_valid  in  1  input sample valid
- x_ready  out  1  block accepts a sample
- x_data  in  DATA_W  signed Q4.4 input sample
- z_valid  out  1  result valid
- z_ready  in  1  downstream accepts the result
- z_value  out  DATA_W  signed Q4.4 pre-activation value
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, count=0, acc=0, all weights and bias=0.
  - x_ready=0, z_valid=0, z_value=0, busy=0.
- States: IDLE, ACCUM, ROUND, OUT.
- IDLE:
  - x_ready=1. On a handshake (x_valid & x_ready):
    - acc ← (sign_ext(bias) << FRAC_W) + w[0]·x.
    - count ← 1; go to ACCUM.
  - If N_INPUTS handshakes have completed, go to ROUND instead (not reachable while N_INPUTS ≥ 2).
- ACCUM:
  - x_ready=1. Each handshake: acc ← acc + w[count]·x, count ← count+1.
  - When the handshake with count = N_INPUTS-1 occurs, go to ROUND.
  - Without x_valid, hold state and acc.
- ROUND (1 cycle):
  - x_ready=0.
  - z_value ← requant(acc); z_valid ← 1; go to OUT.
- OUT:
  - x_ready=0; z_value is held stable while z_valid=1.
  - On z_ready, next cycle: z_valid=0, count=0, state=IDLE.
- Latency: last sample handshake at cycle t gives z_valid=1 at cycle t+2. Peak throughput is one vector per N_INPUTS+2 cycles.
- Arithmetic:
  - Products are full-precision signed 2·DATA_W (Q8.8), sign-extended to ACC_W. There is no intermediate overflow.
  - requant: r = (acc + 2^(FRAC_W-1)) >>> FRAC_W (arithmetic shift; round half toward +∞).
  - Then narrow r to DATA_W per the optional feature.
- Parameter writes:
  - Accepted only in IDLE; they take effect from the next cycle.
  - Writes in ACCUM/ROUND/OUT are ignored.
  - Writes to addresses > N_INPUTS are ignored.
  - A write and an x handshake in the same IDLE cycle: the handshake uses the old value.
- Boundaries:
  - x_valid during ROUND/OUT is not accepted (x_ready=0).
  - z_ready without z_valid has no effect.
  - rst_n low at any point aborts the vector immediately. No partial z is emitted.

Optional Feature:
- Macro: NEURON_MAC_SAT_EN.
- Defined: r is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. 0x80..0x7F.
- Undefined: z_value = r[DATA_W-1:0], i.e. two's-complement wrap.
- All other timing is identical in both builds.

Decomposition:
- Package neuron_pkg:
  - DATA_W and FRAC_W default constants.
  - Signed fixed-point typedef fx_t (DATA_W).
  - Accumulator typedef acc_t.
  - State enum {IDLE, ACCUM, ROUND, OUT}.
- Sub-module neuron_mac_requant (combinational round + saturate/wrap, acc_t → fx_t). It hosts the NEURON_MAC_SAT_EN switch.

Test Plan:
- All weights 0x10 (1.0), bias 0x00; x = 0x10, 0x20, 0x08, 0xF0 → z_value=0x28 (2.5); z_valid 2 cycles after the 4th handshake.
- Weights 0x70, x = 0x70 ×4, bias 0 → SAT_EN: 0x7F; no SAT_EN: 0x40. Weights 0x70, x = 0x80 ×4 → SAT_EN: 0x80.
- Rounding: w[0]=0x01, x[0]=0x08, other x=0, bias 0 → 0x01. Same with x[0]=0xF8 → 0x00.
- Backpressure: hold z_ready=0 for 5 cycles → z_value is stable, x_ready=0 throughout. z_ready=1 → z_valid drops next cycle, x_ready=1.
- Gapped x_valid (1 of every 3 cycles), bias 0x18 (1.5), weights 0x10, x = 0x10 ×4 → 0x58. A weight write mid-vector is ignored.
- rst_n pulsed low after 2 samples → z_valid=0 and busy=0 immediately, weights cleared. A fresh vector with weights 0 and bias 0 gives 0x00.
